// File: rtl/key_encoder.sv
// key_encoder: debounced highest-key priority encoder with held/press/release indications
// Ports:
//   i_clk      rising-edge clock
//   i_reset    synchronous active-high reset
//   i_keys     raw key levels (asynchronous), 1 = pressed
//   i_enable   0 treats all keys as released
//   o_note     last accepted note index (kept after release)
//   o_valid    an accepted note is held
//   o_press    one-cycle pulse on a newly held or changed note
//   o_release  one-cycle pulse when the held note goes to none
module key_encoder #(
  parameter int N_KEYS    = 8,
  parameter int IDX_W     = 3,
  parameter int DB_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_KEYS-1:0] i_keys,
  input  logic              i_enable,
  output logic [IDX_W-1:0]  o_note,
  output logic              o_valid,
  output logic              o_press,
  output logic              o_release
);
  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);
  logic [N_KEYS-1:0] r_sync1, r_sync2;
  logic              r_valid, r_press, r_release, r_state;
  logic [IDX_W-1:0]  r_note;
  logic [IDX_W:0]    r_pend;
  logic [7:0]        r_cnt;
  logic              w_cv;
  logic [IDX_W-1:0]  w_ci;
  logic [IDX_W:0]    w_cur, w_acc;
  always_comb begin
    w_ci = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (r_sync2[i]) w_ci = IDX_W'(i);
    w_cv  = i_enable & |r_sync2;
    w_cur = {w_cv, w_cv ? w_ci : '0};
  end
  // The note is retained after release, so the comparable code masks it when not valid.
  assign w_acc = {r_valid, r_valid ? r_note : '0};
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_valid   <= 1'b0;
      r_note    <= '0;
      r_pend    <= '0;
      r_cnt     <= '0;
      r_state   <= ST_STABLE;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_keys;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (r_state == ST_STABLE) begin
        if (w_cur != w_acc) begin
          r_pend  <= w_cur;
          r_cnt   <= 8'd1;
          r_state <= ST_PENDING;
        end
      end else if (w_cur == w_acc) begin
        r_state <= ST_STABLE;
      end else if (w_cur != r_pend) begin
        r_pend <= w_cur;
        r_cnt  <= 8'd1;
      end else if (r_cnt < CNT_LAST) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_valid   <= r_pend[IDX_W];
        r_note    <= r_pend[IDX_W] ? r_pend[IDX_W-1:0] : r_note;
        r_press   <= r_pend[IDX_W];
        r_release <= r_valid & ~r_pend[IDX_W];
        r_state   <= ST_STABLE;
      end
    end
  end
  assign o_note    = r_note;
  assign o_valid   = r_valid;
  assign o_press   = r_press;
  assign o_release = r_release;
endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder: randomized and directed checking of key_encoder against a sample-history model
module tb_key_encoder;
  localparam int DB = 4;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keys;
  logic       en;
  logic [2:0] note;
  logic       valid, press, rel;
  int checks = 0;
  int errors = 0;
  logic [7:0] s1, s2;
  int hist[$];
  int acc, m_note, cnt_p, cnt_r;
  bit m_press, m_rel;
  always #5 clk = ~clk;
  key_encoder #(.N_KEYS(8), .IDX_W(3), .DB_CYCLES(DB)) dut (
    .i_clk(clk), .i_reset(rst), .i_keys(keys), .i_enable(en),
    .o_note(note), .o_valid(valid), .o_press(press), .o_release(rel)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int code_of(input logic [7:0] s, input bit e);
    if (!e) return 0;
    for (int i = 7; i >= 0; i--)
      if (s[i]) return i + 1;
    return 0;
  endfunction
  task automatic step(input logic [7:0] k, input bit e, input bit r);
    int c;
    bit same;
    keys = k;
    en   = e;
    rst  = r;
    @(posedge clk);
    m_press = 0;
    m_rel   = 0;
    if (r) begin
      s1 = 0; s2 = 0; hist.delete(); acc = 0; m_note = 0;
    end else begin
      c  = code_of(s2, e);
      s2 = s1;
      s1 = k;
      hist.push_back(c);
      if (hist.size() > DB) void'(hist.pop_front());
      same = hist.size() == DB;
      foreach (hist[i]) if (hist[i] != c) same = 0;
      if (same && c != acc) begin
        m_press = c != 0;
        m_rel   = acc != 0 && c == 0;
        acc     = c;
        if (c != 0) m_note = c - 1;
      end
    end
    #1;
    check("note", note, m_note);
    check("valid", valid, acc != 0);
    check("press", press, m_press);
    check("release", rel, m_rel);
    check("excl", press & rel, 0);
    cnt_p += press;
    cnt_r += rel;
  endtask
  task automatic hold(input logic [7:0] k, input bit e, input int n);
    for (int i = 0; i < n; i++) step(k, e, 0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      step(8'hFF, 1, 1);
      check("rst_out", {note, valid, press, rel}, 0);
    end
    step(8'h00, 1, 0);
    check("post_rst_out", {note, valid, press, rel}, 0);
    hold(8'h00, 1, 6);
    for (int i = 0; i < 6; i++) begin
      step(8'h04, 1, 0);
      check("press_lat", press, i == 5);
    end
    check("press_note", note, 2);
    step(8'h04, 1, 0);
    check("press_once", press, 0);
    for (int i = 0; i < 6; i++) begin
      step(8'h00, 1, 0);
      check("rel_lat", rel, i == 5);
    end
    check("rel_note_kept", {note, valid}, {3'd2, 1'b0});
    hold(8'h04, 1, 6);
    cnt_p = 0; cnt_r = 0;
    hold(8'h24, 1, 6);
    check("prio_note", note, 5);
    check("prio_pulses", {cnt_p[3:0], cnt_r[3:0]}, {4'd1, 4'd0});
    hold(8'h04, 1, 6);
    check("back_note", note, 2);
    cnt_p = 0; cnt_r = 0;
    hold(8'h00, 1, 3);
    hold(8'h04, 1, 8);
    check("glitch", {cnt_p[3:0], cnt_r[3:0], valid, note}, {4'd0, 4'd0, 1'b1, 3'd2});
    hold(8'h00, 1, 6);
    cnt_p = 0; cnt_r = 0;
    hold(8'h80, 1, 2);
    hold(8'h00, 1, 8);
    check("blip", {cnt_p[3:0], valid}, {4'd0, 1'b0});
    hold(8'h04, 1, 6);
    cnt_r = 0;
    hold(8'h04, 0, 6);
    check("en_rel", {cnt_r[3:0], valid}, {4'd1, 1'b0});
    cnt_p = 0;
    hold(8'h04, 1, 6);
    check("en_press", {cnt_p[3:0], valid, note}, {4'd1, 1'b1, 3'd2});
    hold(8'h00, 1, 6);
    hold(8'h10, 1, 3);
    step(8'h10, 1, 1);
    check("midq_rst", {note, valid, press, rel}, 0);
    for (int i = 0; i < 6; i++) begin
      step(8'h10, 1, 0);
      check("midq_press", press, i == 5);
    end
    check("midq_note", note, 4);
    for (int n = 0; n < 600; n++) begin
      int kind;
      logic [7:0] k;
      kind = $urandom_range(0, 9);
      k = kind < 3 ? 8'h00 : kind < 7 ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      if ($urandom_range(0, 49) == 0) step(k, 1, 1);
      else hold(k, $urandom_range(0, 7) != 0, $urandom_range(1, 7));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
